// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//   Execute stage of the 5-stage pipeline. Takes the decode/execute latch
//   outputs (e_*), forwards operands from the EX/MEM latch and the writeback
//   stage, runs the ALU, resolves branches/jumps, detects signed overflow and
//   registers the results into the EX/MEM latch (m_*).
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   em_state          latch control from hazard unit: 0 load, 1 hold,
//                     2 bubble, 3 hold
//   e_*               decoded instruction fields and register read data
//   w_RegWrite/w_wsel/w_wdat  writeback-stage forwarding source
//   m_*               EX/MEM latch contents, feed the memory stage
//   br_taken/br_target combinational redirect to fetch
//   lu_hazard         combinational load-use stall request
// ----------------------------------------------------------------------------
module execute_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int SHAM_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        em_state,

    input  logic [WORD_W-1:0] e_pc4,
    input  logic [WORD_W-1:0] e_rdat1,
    input  logic [WORD_W-1:0] e_rdat2,
    input  logic [WORD_W-1:0] e_sign_ext,
    input  logic [WORD_W-1:0] e_taddr,
    input  logic [REG_W-1:0]  e_rs,
    input  logic [REG_W-1:0]  e_rt,
    input  logic [REG_W-1:0]  e_rd,
    input  logic [SHAM_W-1:0] e_shift_amt,
    input  logic [5:0]        e_op,
    input  logic [3:0]        e_alu_op,
    input  logic [1:0]        e_RegDst,
    input  logic [1:0]        e_ALUSrc,
    input  logic [1:0]        e_PCSrc,
    input  logic [1:0]        e_MemToReg,
    input  logic              e_dREN,
    input  logic              e_dWEN,
    input  logic              e_RegWrite,
    input  logic              e_halt,
    input  logic              e_check_zero,
    input  logic              e_check_overflow,

    input  logic              w_RegWrite,
    input  logic [REG_W-1:0]  w_wsel,
    input  logic [WORD_W-1:0] w_wdat,

    output logic [WORD_W-1:0] m_pc4,
    output logic [WORD_W-1:0] m_alu_out,
    output logic [WORD_W-1:0] m_store_dat,
    output logic [REG_W-1:0]  m_wsel,
    output logic [1:0]        m_MemToReg,
    output logic              m_dREN,
    output logic              m_dWEN,
    output logic              m_RegWrite,
    output logic              m_halt,
    output logic              m_overflow,

    output logic              br_taken,
    output logic [WORD_W-1:0] br_target,
    output logic              lu_hazard
);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Signed overflow of a two-operand add/sub, judged from the sign bits of
    // the operands and the wrapped result.
    function automatic logic add_ovf(input logic signed [WORD_W-1:0] a,
                                     input logic signed [WORD_W-1:0] b,
                                     input logic signed [WORD_W-1:0] r);
        return (a[WORD_W-1] == b[WORD_W-1]) && (r[WORD_W-1] != a[WORD_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WORD_W-1:0] a,
                                     input logic signed [WORD_W-1:0] b,
                                     input logic signed [WORD_W-1:0] r);
        return (a[WORD_W-1] != b[WORD_W-1]) && (r[WORD_W-1] != a[WORD_W-1]);
    endfunction

    logic [WORD_W-1:0]        fwd_rs_p0;
    logic [WORD_W-1:0]        fwd_rt_p0;
    logic signed [WORD_W-1:0] op_a_p0;
    logic signed [WORD_W-1:0] op_b_p0;
    logic signed [WORD_W-1:0] sum_p0;
    logic signed [WORD_W-1:0] diff_p0;
    logic [WORD_W-1:0]        alu_res_p0;
    logic                     alu_ovf_p0;
    logic                     zero_p0;
    logic                     ovf_p0;
    logic [REG_W-1:0]         wsel_p0;
    logic [WORD_W-1:0]        alu_out_p0;

    // Fields this stage receives but does not need.
    logic unused_fields;
    assign unused_fields = ^{e_op, e_taddr[WORD_W-1:WORD_W-6]};

    // ---- stage p0: forwarding, ALU, branch resolution (combinational) ----
    // A load in MEM has no data yet, so it is not a forwarding source; that
    // case is covered by lu_hazard stalling the pipe.
    always_comb begin
        fwd_rs_p0 = e_rdat1;
        if (m_RegWrite && !m_dREN && m_wsel != '0 && m_wsel == e_rs)
            fwd_rs_p0 = m_alu_out;
        else if (w_RegWrite && w_wsel != '0 && w_wsel == e_rs)
            fwd_rs_p0 = w_wdat;
    end

    always_comb begin
        fwd_rt_p0 = e_rdat2;
        if (m_RegWrite && !m_dREN && m_wsel != '0 && m_wsel == e_rt)
            fwd_rt_p0 = m_alu_out;
        else if (w_RegWrite && w_wsel != '0 && w_wsel == e_rt)
            fwd_rt_p0 = w_wdat;
    end

    assign op_a_p0 = fwd_rs_p0;

    always_comb begin
        case (e_ALUSrc)
            2'd0:    op_b_p0 = fwd_rt_p0;
            2'd1:    op_b_p0 = e_sign_ext;
            2'd2:    op_b_p0 = {e_sign_ext[15:0], {(WORD_W-16){1'b0}}};
            default: op_b_p0 = {{(WORD_W-SHAM_W){1'b0}}, e_shift_amt};
        endcase
    end

    assign sum_p0  = op_a_p0 + op_b_p0;
    assign diff_p0 = op_a_p0 - op_b_p0;

    always_comb begin
        alu_res_p0 = '0;
        alu_ovf_p0 = 1'b0;
        case (e_alu_op)
            ALU_SLL:  alu_res_p0 = op_a_p0 << op_b_p0[4:0];
            ALU_SRL:  alu_res_p0 = op_a_p0 >> op_b_p0[4:0];
            ALU_ADD: begin
                alu_res_p0 = sum_p0;
                alu_ovf_p0 = add_ovf(op_a_p0, op_b_p0, sum_p0);
            end
            ALU_SUB: begin
                alu_res_p0 = diff_p0;
                alu_ovf_p0 = sub_ovf(op_a_p0, op_b_p0, diff_p0);
            end
            ALU_AND:  alu_res_p0 = op_a_p0 & op_b_p0;
            ALU_OR:   alu_res_p0 = op_a_p0 | op_b_p0;
            ALU_XOR:  alu_res_p0 = op_a_p0 ^ op_b_p0;
            ALU_NOR:  alu_res_p0 = ~(op_a_p0 | op_b_p0);
            ALU_SLT:  alu_res_p0 = {{(WORD_W-1){1'b0}}, (op_a_p0 < op_b_p0)};
            ALU_SLTU: alu_res_p0 = {{(WORD_W-1){1'b0}},
                                    ($unsigned(op_a_p0) < $unsigned(op_b_p0))};
            default:  alu_res_p0 = '0;
        endcase
    end

    assign zero_p0 = (alu_res_p0 == '0);
    assign ovf_p0  = e_check_overflow & alu_ovf_p0;

    always_comb begin
        case (e_RegDst)
            2'd1:    wsel_p0 = e_rd;
            2'd2:    wsel_p0 = REG_W'(31);
            default: wsel_p0 = e_rt;
        endcase
    end

    // JAL writes the return address instead of the ALU result.
    assign alu_out_p0 = (e_RegDst == 2'd2) ? e_pc4 : alu_res_p0;

    always_comb begin
        br_taken  = 1'b0;
        br_target = e_pc4;
        case (e_PCSrc)
            2'd1: begin
                br_taken  = (zero_p0 == e_check_zero);
                br_target = e_pc4 + (e_sign_ext << 2);
            end
            2'd2: begin
                br_taken  = 1'b1;
                br_target = {e_pc4[WORD_W-1:WORD_W-4], e_taddr[WORD_W-7:0], 2'b00};
            end
            2'd3: begin
                br_taken  = 1'b1;
                br_target = fwd_rs_p0;
            end
            default: ;
        endcase
        // A bubbled instruction must never redirect fetch.
        if (em_state == ST_FLUSH)
            br_taken = 1'b0;
    end

    assign lu_hazard = m_dREN && (m_wsel != '0) && ((m_wsel == e_rs) || (m_wsel == e_rt));

    // ---- stage p1: EX/MEM latch ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_pc4       <= '0;
            m_alu_out   <= '0;
            m_store_dat <= '0;
            m_wsel      <= '0;
            m_MemToReg  <= '0;
            m_dREN      <= 1'b0;
            m_dWEN      <= 1'b0;
            m_RegWrite  <= 1'b0;
            m_halt      <= 1'b0;
            m_overflow  <= 1'b0;
        end else if (em_state == ST_NORMAL) begin
            m_pc4       <= e_pc4;
            m_alu_out   <= alu_out_p0;
            m_store_dat <= fwd_rt_p0;
            m_wsel      <= wsel_p0;
            m_MemToReg  <= e_MemToReg;
            m_dREN      <= e_dREN;
            m_dWEN      <= e_dWEN & ~ovf_p0;
            m_RegWrite  <= e_RegWrite & ~ovf_p0;
            m_halt      <= m_halt | e_halt;
            m_overflow  <= ovf_p0;
        end else if (em_state == ST_FLUSH) begin
            // Bubble; halt is sticky so it is left untouched.
            m_pc4       <= '0;
            m_alu_out   <= '0;
            m_store_dat <= '0;
            m_wsel      <= '0;
            m_MemToReg  <= '0;
            m_dREN      <= 1'b0;
            m_dWEN      <= 1'b0;
            m_RegWrite  <= 1'b0;
            m_overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  em_state;
    logic [31:0] e_pc4, e_rdat1, e_rdat2, e_sign_ext, e_taddr;
    logic [4:0]  e_rs, e_rt, e_rd, e_shift_amt;
    logic [5:0]  e_op;
    logic [3:0]  e_alu_op;
    logic [1:0]  e_RegDst, e_ALUSrc, e_PCSrc, e_MemToReg;
    logic        e_dREN, e_dWEN, e_RegWrite, e_halt, e_check_zero, e_check_overflow;
    logic        w_RegWrite;
    logic [4:0]  w_wsel;
    logic [31:0] w_wdat;
    logic [31:0] m_pc4, m_alu_out, m_store_dat;
    logic [4:0]  m_wsel;
    logic [1:0]  m_MemToReg;
    logic        m_dREN, m_dWEN, m_RegWrite, m_halt, m_overflow;
    logic        br_taken, lu_hazard;
    logic [31:0] br_target;

    execute_stage dut (
        .CLK(CLK), .RST(RST), .em_state(em_state),
        .e_pc4(e_pc4), .e_rdat1(e_rdat1), .e_rdat2(e_rdat2), .e_sign_ext(e_sign_ext),
        .e_taddr(e_taddr), .e_rs(e_rs), .e_rt(e_rt), .e_rd(e_rd),
        .e_shift_amt(e_shift_amt), .e_op(e_op), .e_alu_op(e_alu_op),
        .e_RegDst(e_RegDst), .e_ALUSrc(e_ALUSrc), .e_PCSrc(e_PCSrc), .e_MemToReg(e_MemToReg),
        .e_dREN(e_dREN), .e_dWEN(e_dWEN), .e_RegWrite(e_RegWrite), .e_halt(e_halt),
        .e_check_zero(e_check_zero), .e_check_overflow(e_check_overflow),
        .w_RegWrite(w_RegWrite), .w_wsel(w_wsel), .w_wdat(w_wdat),
        .m_pc4(m_pc4), .m_alu_out(m_alu_out), .m_store_dat(m_store_dat), .m_wsel(m_wsel),
        .m_MemToReg(m_MemToReg), .m_dREN(m_dREN), .m_dWEN(m_dWEN), .m_RegWrite(m_RegWrite),
        .m_halt(m_halt), .m_overflow(m_overflow),
        .br_taken(br_taken), .br_target(br_target), .lu_hazard(lu_hazard)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference copy of the EX/MEM latch.
    logic [31:0] mm_pc4, mm_alu, mm_store;
    logic [4:0]  mm_wsel;
    logic [1:0]  mm_mtr;
    logic        mm_dren, mm_dwen, mm_rw, mm_halt, mm_ovf;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (mm_rw && !mm_dren && mm_wsel != 0 && mm_wsel == r) return mm_alu;
        if (w_RegWrite && w_wsel != 0 && w_wsel == r) return w_wdat;
        return d;
    endfunction

    task automatic clear_in();
        RST = 0; em_state = 0;
        e_pc4 = 0; e_rdat1 = 0; e_rdat2 = 0; e_sign_ext = 0; e_taddr = 0;
        e_rs = 0; e_rt = 0; e_rd = 0; e_shift_amt = 0; e_op = 0; e_alu_op = 0;
        e_RegDst = 0; e_ALUSrc = 0; e_PCSrc = 0; e_MemToReg = 0;
        e_dREN = 0; e_dWEN = 0; e_RegWrite = 0; e_halt = 0;
        e_check_zero = 0; e_check_overflow = 0;
        w_RegWrite = 0; w_wsel = 0; w_wdat = 0;
    endtask

    // Evaluate the reference for the current inputs, check combinational
    // outputs (optional), clock once, then check the latch.
    task automatic step(input bit do_comb);
        logic [31:0] a, b, r, fb, tgt;
        longint sa, sb, s;
        bit ov, z, tk, lu, ovf;
        a  = fwd(e_rs, e_rdat1);
        fb = fwd(e_rt, e_rdat2);
        case (e_ALUSrc)
            0: b = fb;
            1: b = e_sign_ext;
            2: b = e_sign_ext << 16;
            default: b = {27'd0, e_shift_amt};
        endcase
        case (e_alu_op)
            0: r = a << b[4:0];
            1: r = a >> b[4:0];
            2: r = a + b;
            3: r = a - b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = ~(a | b);
            8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 0;
        endcase
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = (e_alu_op == A_ADD) ? sa + sb : sa - sb;
        ov = (e_alu_op == A_ADD || e_alu_op == A_SUB) &&
             (s > 64'sd2147483647 || s < -64'sd2147483648);
        z  = (r == 0);
        case (e_PCSrc)
            1: begin tk = (z == e_check_zero); tgt = e_pc4 + e_sign_ext * 4; end
            2: begin tk = 1; tgt = {e_pc4[31:28], e_taddr[25:0], 2'b00}; end
            3: begin tk = 1; tgt = a; end
            default: begin tk = 0; tgt = e_pc4; end
        endcase
        if (em_state == 2) tk = 0;
        lu = mm_dren && mm_wsel != 0 && (mm_wsel == e_rs || mm_wsel == e_rt);
        if (do_comb) begin
            #1;
            chk_val("br_taken", br_taken, tk);
            chk_val("br_target", br_target, tgt);
            chk_val("lu_hazard", lu_hazard, lu);
        end
        ovf = e_check_overflow && ov;
        @(posedge CLK);
        if (RST) begin
            mm_pc4 = 0; mm_alu = 0; mm_store = 0; mm_wsel = 0; mm_mtr = 0;
            mm_dren = 0; mm_dwen = 0; mm_rw = 0; mm_halt = 0; mm_ovf = 0;
        end else if (em_state == 0) begin
            mm_pc4 = e_pc4; mm_alu = (e_RegDst == 2) ? e_pc4 : r; mm_store = fb;
            mm_wsel = (e_RegDst == 1) ? e_rd : (e_RegDst == 2) ? 5'd31 : e_rt;
            mm_mtr = e_MemToReg; mm_dren = e_dREN; mm_dwen = e_dWEN && !ovf;
            mm_rw = e_RegWrite && !ovf; mm_halt = mm_halt || e_halt; mm_ovf = ovf;
        end else if (em_state == 2) begin
            mm_pc4 = 0; mm_alu = 0; mm_store = 0; mm_wsel = 0; mm_mtr = 0;
            mm_dren = 0; mm_dwen = 0; mm_rw = 0; mm_ovf = 0;
        end
        #1;
        chk_val("m_pc4", m_pc4, mm_pc4);
        chk_val("m_alu_out", m_alu_out, mm_alu);
        chk_val("m_store_dat", m_store_dat, mm_store);
        chk_val("m_wsel", m_wsel, mm_wsel);
        chk_val("m_MemToReg", m_MemToReg, mm_mtr);
        chk_val("m_dREN", m_dREN, mm_dren);
        chk_val("m_dWEN", m_dWEN, mm_dwen);
        chk_val("m_RegWrite", m_RegWrite, mm_rw);
        chk_val("m_halt", m_halt, mm_halt);
        chk_val("m_overflow", m_overflow, mm_ovf);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        mm_pc4 = 0; mm_alu = 0; mm_store = 0; mm_wsel = 0; mm_mtr = 0;
        mm_dren = 0; mm_dwen = 0; mm_rw = 0; mm_halt = 0; mm_ovf = 0;
        clear_in();
        @(negedge CLK);

        // Reset with busy inputs
        e_rdat1 = 32'h1234; e_pc4 = 32'h100; e_RegWrite = 1; e_halt = 1;
        e_dREN = 1; e_rt = 5; e_alu_op = A_ADD; RST = 1;
        step(0);
        step(1);
        chk_val("rst_alu", m_alu_out, 0);
        chk_val("rst_halt", m_halt, 0);
        chk_val("rst_rw", m_RegWrite, 0);
        chk_val("rst_br", br_taken, 0);

        // Preload MEM latch: reg 3 <= 0x10
        clear_in(); e_alu_op = A_ADD; e_ALUSrc = 1; e_rdat1 = 32'h10;
        e_rt = 3; e_RegWrite = 1;
        step(1);
        chk_val("pre_wsel", m_wsel, 3);
        // Forward from MEM with WB also targeting reg 3
        clear_in(); e_alu_op = A_ADD; e_ALUSrc = 1; e_sign_ext = 5; e_rs = 3;
        e_rdat1 = 32'h99; w_RegWrite = 1; w_wsel = 3; w_wdat = 32'h20;
        step(1);
        chk_val("fwd_mem", m_alu_out, 32'h15);
        // m_wsel = 0 is never a forwarding source
        clear_in(); e_alu_op = A_ADD; e_ALUSrc = 1; e_rdat1 = 32'h10; e_RegWrite = 1;
        step(1);
        clear_in(); e_alu_op = A_ADD; e_ALUSrc = 1; e_sign_ext = 5; e_rdat1 = 32'h99;
        step(1);
        chk_val("fwd_r0", m_alu_out, 32'h9E);

        // Overflow
        clear_in(); e_alu_op = A_ADD; e_ALUSrc = 1; e_sign_ext = 1;
        e_rdat1 = 32'h7FFF_FFFF; e_check_overflow = 1; e_RegWrite = 1; e_dWEN = 1;
        step(1);
        chk_val("ovf_flag", m_overflow, 1);
        chk_val("ovf_rw", m_RegWrite, 0);
        chk_val("ovf_dwen", m_dWEN, 0);
        e_check_overflow = 0;
        step(1);
        chk_val("noovf_alu", m_alu_out, 32'h8000_0000);
        chk_val("noovf_rw", m_RegWrite, 1);

        // BEQ taken
        clear_in(); e_alu_op = A_SUB; e_rdat1 = 5; e_rdat2 = 5; e_rs = 1; e_rt = 2;
        e_PCSrc = 1; e_check_zero = 1; e_pc4 = 32'h104; e_sign_ext = 4;
        #1;
        chk_val("beq_taken", br_taken, 1);
        chk_val("beq_target", br_target, 32'h114);
        step(1);
        // JR
        clear_in(); e_PCSrc = 3; e_rs = 4; e_rdat1 = 32'h200;
        #1;
        chk_val("jr_target", br_target, 32'h200);
        chk_val("jr_taken", br_taken, 1);
        step(1);
        // JAL
        clear_in(); e_RegDst = 2; e_pc4 = 32'h40; e_RegWrite = 1; e_PCSrc = 2; e_taddr = 32'h10;
        step(1);
        chk_val("jal_wsel", m_wsel, 31);
        chk_val("jal_alu", m_alu_out, 32'h40);

        // STALL holds for 3 cycles (reserved encoding in the last one)
        for (int i = 0; i < 3; i++) begin
            clear_in(); em_state = (i == 2) ? 2'd3 : 2'd1;
            e_rdat1 = $urandom(); e_pc4 = $urandom(); e_rt = 6; e_RegWrite = 1;
            step(1);
            chk_val("stall_alu", m_alu_out, 32'h40);
        end

        // FLUSH zeroes latch and suppresses redirect
        clear_in(); em_state = 2; e_PCSrc = 2; e_rdat1 = 7; e_RegWrite = 1;
        #1;
        chk_val("flush_br", br_taken, 0);
        step(1);
        chk_val("flush_alu", m_alu_out, 0);
        chk_val("flush_wsel", m_wsel, 0);

        // Sticky halt survives FLUSH
        clear_in(); e_halt = 1;
        step(1);
        clear_in(); em_state = 2;
        step(1);
        chk_val("halt_sticky", m_halt, 1);

        // Load-use
        clear_in(); e_dREN = 1; e_rt = 7; e_RegWrite = 1;
        step(1);
        clear_in(); e_rt = 7;
        #1;
        chk_val("lu_rt", lu_hazard, 1);
        step(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int st;
            clear_in();
            RST = ($urandom_range(0, 39) == 0);
            st = $urandom_range(0, 9);
            em_state = (st < 6) ? 2'd0 : (st < 8) ? 2'd1 : (st == 8) ? 2'd2 : 2'd3;
            e_pc4 = rnd_word(); e_rdat1 = rnd_word(); e_rdat2 = rnd_word();
            e_sign_ext = ($urandom_range(0, 1) != 0) ? 32'($signed(16'($urandom()))) : rnd_word();
            e_taddr = $urandom();
            e_rs = 5'($urandom_range(0, 7)); e_rt = 5'($urandom_range(0, 7));
            e_rd = 5'($urandom_range(0, 7)); e_shift_amt = 5'($urandom());
            e_op = 6'($urandom()); e_alu_op = 4'($urandom_range(0, 11));
            e_RegDst = 2'($urandom()); e_ALUSrc = 2'($urandom());
            e_PCSrc = 2'($urandom()); e_MemToReg = 2'($urandom());
            e_dREN = ($urandom_range(0, 3) == 0); e_dWEN = 1'($urandom());
            e_RegWrite = 1'($urandom()); e_halt = ($urandom_range(0, 63) == 0);
            e_check_zero = 1'($urandom()); e_check_overflow = 1'($urandom());
            w_RegWrite = 1'($urandom()); w_wsel = 5'($urandom_range(0, 7)); w_wdat = rnd_word();
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the decode/execute latch and consumes its e_* outputs.
- Performs operand forwarding, ALU operation, branch/jump resolution and overflow detection.
- Registers results into the execute/memory (EX/MEM) latch, whose m_* outputs drive the memory stage.
- Latch is controlled by a pipe-state input from the hazard unit.

Parameters:
- WORD_W, 32, datapath width
- REG_W, 5, register index width
- SHAM_W, 5, shift amount width

Ports:
- CLK in 1: clock, rising edge
- RST in 1: reset, synchronous, active-high
- em_state in 2: 0 = NORMAL (load), 1 = STALL (hold), 2 = FLUSH (bubble), 3 = reserved, treated as STALL
- e_pc4, e_rdat1, e_rdat2, e_sign_ext, e_taddr in WORD_W: from decode/execute latch
- e_rs, e_rt, e_rd in REG_W; e_shift_amt in SHAM_W; e_op in 6; e_alu_op in 4
- e_RegDst, e_ALUSrc, e_PCSrc, e_MemToReg in 2 each
- e_dREN, e_dWEN, e_RegWrite, e_halt, e_check_zero, e_check_overflow in 1 each
- w_RegWrite in 1, w_wsel in REG_W, w_wdat in WORD_W: writeback-stage forwarding source
- m_pc4, m_alu_out, m_store_dat in WORD_W out: EX/MEM latch
- m_wsel in REG_W out; m_MemToReg in 2 out
- m_dREN, m_dWEN, m_RegWrite, m_halt, m_overflow in 1 out
- br_taken out 1, br_target out WORD_W: combinational redirect to fetch
- lu_hazard out 1: load-use stall request to hazard unit

Behaviour:
- Reset (RST high at a CLK edge): every m_* output is 0. RST overrides em_state.
- Forwarding, rs (rt identical):
  - Source is m_alu_out when m_RegWrite, !m_dREN, m_wsel != 0 and m_wsel == e_rs.
  - Otherwise w_wdat when w_RegWrite, w_wsel != 0 and w_wsel == e_rs.
  - Otherwise e_rdat1. MEM has priority over WB.
- Operand A = forwarded rs.
- Operand B by e_ALUSrc: 0 forwarded rt; 1 e_sign_ext; 2 {e_sign_ext[15:0], 16'h0} (LUI); 3 zero-extended e_shift_amt.
- ALU ops: SLL, SRL (B shifts A by B[4:0]), ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU.
  - Unknown encodings produce 0.
  - zero = (result == 0).
  - Signed overflow on ADD/SUB: operand signs equal (ADD) or differ (SUB) and result sign differs from A.
- Overflow: ovf = e_check_overflow & overflow. On ovf the latch loads RegWrite = 0, dWEN = 0 and m_overflow = 1.
- Write select by e_RegDst: 0 e_rt; 1 e_rd; 2 5'd31 (JAL); 3 e_rt.
- JAL (e_RegDst == 2): m_alu_out = e_pc4.
- m_store_dat = forwarded rt.
- Branch resolution (combinational, from e_* and forwarding):
  - e_PCSrc 1: branch. Taken if (zero == e_check_zero), with SUB selected by decode. Target = e_pc4 + (e_sign_ext << 2).
  - e_PCSrc 2: target = {e_pc4[31:28], e_taddr[25:0], 2'b00}, always taken.
  - e_PCSrc 3: target = forwarded rs, always taken.
  - e_PCSrc 0: br_taken = 0, br_target = e_pc4.
  - br_taken is forced 0 when em_state == FLUSH.
- Load-use: lu_hazard = m_dREN & m_wsel != 0 & (m_wsel == e_rs | m_wsel == e_rt). Combinational.
- Latch update each CLK edge (RST low):
  - NORMAL: load all computed values.
  - STALL / reserved: hold all.
  - FLUSH: load all zeros (bubble).
- Sticky halt: once m_halt = 1, it stays 1 until RST, regardless of em_state. Other fields follow em_state.
- Latency: inputs appear on m_* one cycle after a NORMAL edge.
- Simultaneous RST and any em_state: reset wins.

Test Plan:
- Reset: pulse RST for 2 cycles with em_state = NORMAL and nonzero inputs -> all m_* = 0, br_taken = 0.
- ADD forwarding: m latch holds wsel = 3, alu_out = 0x10, RegWrite = 1; e_rs = 3, e_rdat1 = 0x99, B = sign_ext 5 -> next cycle m_alu_out = 0x15.
- MEM over WB priority: both stages target reg 3 (MEM 0x10, WB 0x20) -> operand uses 0x10. With m_wsel = 0 -> e_rdat1 used.
- Overflow: ADD 0x7FFFFFFF + 1 with check_overflow = 1 -> m_overflow = 1, m_RegWrite = 0. With check_overflow = 0 -> m_alu_out = 0x80000000, RegWrite = 1.
- BEQ/JR/JAL:
  - BEQ with equal operands, pc4 = 0x104, sign_ext = 4 -> br_target = 0x114, br_taken = 1.
  - JR rs = 0x200 -> target 0x200.
  - JAL -> m_wsel = 31, m_alu_out = pc4.
- Stall/flush/halt and load-use:
  - STALL holds values for 3 cycles.
  - FLUSH zeroes the latch and suppresses br_taken.
  - Latched halt survives a later FLUSH.
  - m_dREN = 1, m_wsel = e_rt = 7 -> lu_hazard = 1.
